// File: rtl/sram_array_pkg.sv
// Shared types and elaboration helpers for the banked 1RW array wrapper.
package sram_array_pkg;

  typedef enum logic {INIT, RUN} init_state_e;

  function automatic int lane_width(input int data_width, input int mask_width);
    return data_width / mask_width;
  endfunction

  // Index width that never collapses to zero bits, so single-entry cases stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit cfg_ok(input int data_width, input int mask_width,
                                input int depth, input int banks);
    return (mask_width > 0) && ((data_width % mask_width) == 0) &&
           is_pow2(depth) && is_pow2(banks) && (banks <= depth);
  endfunction

endpackage

// File: rtl/sram_1rw_macro.sv
// Behavioural stand-in for the sram_<W>x<D>_1rw hard macro: per-bit write mask,
// one-cycle registered read.
module sram_1rw_macro #(
  parameter int WIDTH = 96,
  parameter int ROWS  = 2048,
  parameter int ROW_W = 11
) (
  input  logic             clk,
  input  logic             ce,
  input  logic             we,
  input  logic [ROW_W-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] w_mask,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[addr] <= (mem[addr] & ~w_mask) | (wdata & w_mask);
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_init_seq.sv
// Post-reset zero-fill sequencer: walks every macro row once, then opens the
// array to user traffic until the next reset.
module sram_init_seq
  import sram_array_pkg::*;
#(
  parameter int ROWS      = 2048,
  parameter int INIT_ZERO = 1,
  parameter int ROW_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_active,
  output logic [ROW_W-1:0] init_row,
  output logic             ready
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  init_state_e      state;
  logic [ROW_W-1:0] row_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= (INIT_ZERO != 0) ? INIT : RUN;
      row_cnt <= '0;
    end else if (state == INIT) begin
      if (row_cnt == LAST_ROW) state <= RUN;
      else                     row_cnt <= row_cnt + 1'b1;
    end
  end

  assign init_active = (state == INIT);
  assign ready       = (state == RUN);
  assign init_row    = row_cnt;

endmodule

// File: rtl/sram_array_1rw_banked.sv
// DATA_WIDTH x DEPTH single-port array built from BANKS 1RW macros, with lane
// write masks, optional output register and a hardware zero-fill after reset.
module sram_array_1rw_banked
  import sram_array_pkg::*;
#(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 4096,
  parameter int MASK_WIDTH = 16,
  parameter int BANKS      = 2,
  parameter int OUT_REG    = 1,
  parameter int INIT_ZERO  = 1
) (
  input  logic                     RW0_clk,
  input  logic                     RW0_reset,
  input  logic [$clog2(DEPTH)-1:0] RW0_addr,
  input  logic                     RW0_en,
  input  logic                     RW0_wmode,
  input  logic [DATA_WIDTH-1:0]    RW0_wdata,
  input  logic [MASK_WIDTH-1:0]    RW0_wmask,
  output logic [DATA_WIDTH-1:0]    RW0_rdata,
  output logic                     RW0_rvalid,
  output logic                     RW0_ready
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LANE  = lane_width(DATA_WIDTH, MASK_WIDTH);
  localparam int ROWS  = DEPTH / BANKS;
  localparam int ROW_W = idx_width(ROWS);
  localparam int SEL_W = idx_width(BANKS);

  if (!cfg_ok(DATA_WIDTH, MASK_WIDTH, DEPTH, BANKS)) begin : g_cfg_err
    $error("sram_array_1rw_banked: illegal DATA_WIDTH/MASK_WIDTH/DEPTH/BANKS");
  end

  logic                  init_active;
  logic                  ready;
  logic [ROW_W-1:0]      init_row;
  logic [ROW_W-1:0]      user_row;
  logic [ROW_W-1:0]      mac_addr;
  logic [SEL_W-1:0]      bank_sel;
  logic [DATA_WIDTH-1:0] user_bmask;
  logic [DATA_WIDTH-1:0] mac_bmask;
  logic [DATA_WIDTH-1:0] mac_wdata;
  logic                  mac_we;
  logic                  accept;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mac_rdata [BANKS];
  logic [DATA_WIDTH-1:0] mux_p1;
  logic                  vld_p1;

  sram_init_seq #(
    .ROWS      (ROWS),
    .INIT_ZERO (INIT_ZERO),
    .ROW_W     (ROW_W)
  ) u_init_seq (
    .clk         (RW0_clk),
    .rst         (RW0_reset),
    .init_active (init_active),
    .init_row    (init_row),
    .ready       (ready)
  );

  assign accept = RW0_en & ready;
  assign rd_acc = accept & ~RW0_wmode;

  if (BANKS > 1) begin : g_sel
    assign bank_sel = RW0_addr[AW-1 -: SEL_W];
  end else begin : g_nosel
    assign bank_sel = '0;
  end

  if (ROWS > 1) begin : g_row
    assign user_row = RW0_addr[ROW_W-1:0];
  end else begin : g_norow
    assign user_row = '0;
  end

  for (genvar i = 0; i < MASK_WIDTH; i++) begin : g_mask
    assign user_bmask[i*LANE +: LANE] = {LANE{RW0_wmask[i]}};
  end

  // The sweep owns every macro port while active; ready is low then, so no user access competes.
  assign mac_we    = init_active | RW0_wmode;
  assign mac_addr  = init_active ? init_row : user_row;
  assign mac_wdata = init_active ? '0 : RW0_wdata;
  assign mac_bmask = init_active ? '1 : user_bmask;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic ce;
    assign ce = init_active | (accept & (bank_sel == SEL_W'(b)));

    sram_1rw_macro #(
      .WIDTH (DATA_WIDTH),
      .ROWS  (ROWS),
      .ROW_W (ROW_W)
    ) u_macro (
      .clk    (RW0_clk),
      .ce     (ce),
      .we     (mac_we),
      .addr   (mac_addr),
      .wdata  (mac_wdata),
      .w_mask (mac_bmask),
      .rdata  (mac_rdata[b])
    );
  end

  // Stage p1: macro output cycle, steered by the bank captured at access time
  always_ff @(posedge RW0_clk or posedge RW0_reset) begin
    if (RW0_reset) vld_p1 <= 1'b0;
    else           vld_p1 <= rd_acc;
  end

  if (BANKS > 1) begin : g_rmux
    logic [SEL_W-1:0] sel_p1;
    always_ff @(posedge RW0_clk) begin
      if (rd_acc) sel_p1 <= bank_sel;
    end
    assign mux_p1 = mac_rdata[sel_p1];
  end else begin : g_rdirect
    assign mux_p1 = mac_rdata[0];
  end

  // Stage p2: optional output register, holds data until the next valid read
  if (OUT_REG != 0) begin : g_oreg
    logic                  vld_p2;
    logic [DATA_WIDTH-1:0] rdata_p2;
    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
      if (RW0_reset) begin
        vld_p2   <= 1'b0;
        rdata_p2 <= '0;
      end else begin
        vld_p2 <= vld_p1;
        if (vld_p1) rdata_p2 <= mux_p1;
      end
    end
    assign RW0_rvalid = vld_p2;
    assign RW0_rdata  = rdata_p2;
  end else begin : g_ocomb
    assign RW0_rvalid = vld_p1;
    assign RW0_rdata  = mux_p1;
  end

  assign RW0_ready = ready;

endmodule

// File: tb/tb_sram_array_1rw_banked.sv
// Bench for sram_array_1rw_banked: default build against a lane-level memory
// model, plus a small unregistered single-bank build.
module tb_sram_array_1rw_banked;

  localparam int DW     = 96;
  localparam int DEP    = 4096;
  localparam int MW     = 16;
  localparam int BK     = 2;
  localparam int LANE   = DW / MW;
  localparam int AW     = 12;
  localparam int ROWS_A = DEP / BK;

  localparam int DW_B = 16;
  localparam int MW_B = 2;
  localparam int AW_B = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, en_a, wmode_a, rvalid_a, ready_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a, rdata_a;
  logic [MW-1:0] wmask_a;

  logic            rst_b, en_b, wmode_b, rvalid_b, ready_b;
  logic [AW_B-1:0] addr_b;
  logic [DW_B-1:0] wdata_b, rdata_b;
  logic [MW_B-1:0] wmask_b;

  sram_array_1rw_banked dut_a (
    .RW0_clk    (clk),
    .RW0_reset  (rst_a),
    .RW0_addr   (addr_a),
    .RW0_en     (en_a),
    .RW0_wmode  (wmode_a),
    .RW0_wdata  (wdata_a),
    .RW0_wmask  (wmask_a),
    .RW0_rdata  (rdata_a),
    .RW0_rvalid (rvalid_a),
    .RW0_ready  (ready_a)
  );

  sram_array_1rw_banked #(
    .DATA_WIDTH (DW_B),
    .DEPTH      (64),
    .MASK_WIDTH (MW_B),
    .BANKS      (1),
    .OUT_REG    (0),
    .INIT_ZERO  (0)
  ) dut_b (
    .RW0_clk    (clk),
    .RW0_reset  (rst_b),
    .RW0_addr   (addr_b),
    .RW0_en     (en_b),
    .RW0_wmode  (wmode_b),
    .RW0_wdata  (wdata_b),
    .RW0_wmask  (wmask_b),
    .RW0_rdata  (rdata_b),
    .RW0_rvalid (rvalid_b),
    .RW0_ready  (ready_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem_m [int];

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Ready is due once ROWS_A edges have passed since reset release.
  function automatic bit exp_ready_a();
    return !rst_a && ((cyc - rel_cyc) >= ROWS_A);
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [MW-1:0] m);
    logic [DW-1:0] w;
    w = model_read(a);
    for (int i = 0; i < MW; i++)
      if (m[i]) w[i*LANE +: LANE] = d[i*LANE +: LANE];
    mem_m[int'(a)] = w;
  endfunction

  always @(negedge clk) begin
    chk("ready_a", {95'b0, ready_a}, {95'b0, exp_ready_a()});
    if (rst_a) begin
      chk("rvalid_in_reset", {95'b0, rvalid_a}, '0);
      chk("rdata_in_reset", rdata_a, '0);
    end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
      chk("rvalid_a", {95'b0, rvalid_a}, 96'd1);
      chk("rdata_a", rdata_a, sbq[0].data);
      void'(sbq.pop_front());
    end else begin
      chk("rvalid_idle", {95'b0, rvalid_a}, '0);
    end
  end

  task automatic issue_a(input logic en, input logic wm, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m,
                         input bit use_exp, input logic [DW-1:0] rexp);
    exp_t e;
    @(negedge clk);
    #1;
    en_a = en; wmode_a = wm; addr_a = a; wdata_a = d; wmask_a = m;
    if (en && exp_ready_a()) begin
      if (wm) model_write(a, d, m);
      else begin
        e.due  = cyc + 2;
        e.data = use_exp ? rexp : model_read(a);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      en_a = 1'b0;
    end
  endtask

  task automatic reset_a(input int hold);
    @(negedge clk);
    #1;
    rst_a = 1'b1;
    en_a  = 1'b0;
    sbq.delete();
    repeat (hold) @(negedge clk);
    #1;
    rst_a   = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_init_a();
    for (int i = 0; i < ROWS_A + 8; i++) begin
      if (exp_ready_a()) break;
      @(negedge clk);
      #1;
    end
    mem_m.delete();
  endtask

  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic [MW-1:0] rm;

  initial begin
    rst_a = 1'b1; en_a = 1'b0; wmode_a = 1'b0; addr_a = '0; wdata_a = '0; wmask_a = '0;
    rst_b = 1'b1; en_b = 1'b0; wmode_b = 1'b0; addr_b = '0; wdata_b = '0; wmask_b = '0;

    vecs[0] = '{12'h005, 96'h0FFF_FFFF, 16'h0003, 96'h0000_0000_0000_0000_0000_0FFF};
    vecs[1] = '{12'h7FF, 96'h1234_5678_9ABC_DEF0_0F1E_2D3C, 16'hFFFF,
                96'h1234_5678_9ABC_DEF0_0F1E_2D3C};
    vecs[2] = '{12'h800, 96'hDEAD_BEEF_CAFE_F00D_55AA_33CC, 16'hFFFF,
                96'hDEAD_BEEF_CAFE_F00D_55AA_33CC};
    vecs[3] = '{12'h005, {96{1'b1}}, 16'h8001, 96'hFC00_0000_0000_0000_0000_0FFF};
    vecs[4] = '{12'hFFF, {96{1'b1}}, 16'h0000, 96'h0};
    vecs[5] = '{12'h001, {24{4'hA}}, 16'h00F0, 96'h0000_0000_0000_AAAA_AA00_0000};

    @(negedge clk);
    chk("ready_b_in_reset", {95'b0, ready_b}, 96'd1);
    chk("rvalid_b_in_reset", {95'b0, rvalid_b}, '0);

    // Default build: first sweep interrupted near row 1000, then a full sweep.
    reset_a(2);
    while ((cyc - rel_cyc) < 999) @(negedge clk);
    reset_a(3);
    while ((cyc - rel_cyc) < 2040) @(negedge clk);
    issue_a(1'b1, 1'b1, 12'h010, {96{1'b1}}, 16'hFFFF, 1'b0, '0);
    issue_a(1'b1, 1'b0, 12'h010, '0, '0, 1'b0, '0);
    idle_a(1);
    wait_init_a();

    issue_a(1'b1, 1'b0, 12'hFFF, '0, '0, 1'b1, '0);
    issue_a(1'b1, 1'b0, 12'h010, '0, '0, 1'b1, '0);
    idle_a(4);

    for (int v = 0; v < 6; v++) begin
      issue_a(1'b1, 1'b1, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, 1'b0, '0);
      issue_a(1'b1, 1'b0, vecs[v].addr, '0, '0, 1'b1, vecs[v].exp);
    end
    idle_a(4);

    issue_a(1'b1, 1'b0, 12'h800, '0, '0, 1'b1, vecs[2].exp);
    issue_a(1'b1, 1'b0, 12'h7FF, '0, '0, 1'b1, vecs[1].exp);
    issue_a(1'b1, 1'b0, 12'h800, '0, '0, 1'b1, vecs[2].exp);
    idle_a(4);

    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 1) != 0) ? 12'h7F8 : 12'h000;
      ra = ra + 12'($urandom_range(0, 15));
      rd = {$urandom(), $urandom(), $urandom()};
      rm = 16'($urandom());
      issue_a($urandom_range(0, 4) != 0, $urandom_range(0, 1) != 0, ra, rd, rm, 1'b0, '0);
    end
    idle_a(4);

    // Read in flight when reset hits: it must vanish, and the sweep re-zeroes the array.
    issue_a(1'b1, 1'b0, 12'h800, '0, '0, 1'b0, '0);
    reset_a(2);
    idle_a(3);
    wait_init_a();
    issue_a(1'b1, 1'b0, 12'h800, '0, '0, 1'b1, '0);
    idle_a(4);

    // Small build: no sweep, combinational read path.
    @(negedge clk);
    #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("ready_b", {95'b0, ready_b}, 96'd1);
    #1;
    en_b = 1'b1; wmode_b = 1'b1; addr_b = 6'd7; wdata_b = 16'hA5A5; wmask_b = 2'b11;
    @(negedge clk);
    chk("rvalid_b_after_write", {95'b0, rvalid_b}, '0);
    #1;
    wmode_b = 1'b0;
    @(negedge clk);
    chk("rvalid_b_t1", {95'b0, rvalid_b}, 96'd1);
    chk("rdata_b_t1", {80'b0, rdata_b}, 96'hA5A5);
    #1;
    wmode_b = 1'b1; wdata_b = 16'h5A5A; wmask_b = 2'b01;
    @(negedge clk);
    chk("rvalid_b_pulse", {95'b0, rvalid_b}, '0);
    #1;
    wmode_b = 1'b0;
    @(negedge clk);
    chk("rvalid_b_masked", {95'b0, rvalid_b}, 96'd1);
    chk("rdata_b_masked", {80'b0, rdata_b}, 96'hA55A);
    #1;
    en_b = 1'b0;
    @(negedge clk);
    chk("rvalid_b_idle", {95'b0, rvalid_b}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
